// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART RX controller.
// Register offsets, STATUS/CTRL bit positions, controller states.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STAT_OVR   = 8;
  localparam int STAT_FULL  = 7;
  localparam int STAT_EMPTY = 6;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQ   = 1;
  localparam int CTRL_FLUSH = 2;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Peripheral bus bundle between the core and the UART RX controller.
// master: sel/we/addr/wdata out, rdata/ready in; slave: the reverse.
interface uart_rx_ctrl_if;

  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output sel, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  sel, we, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO: push/pop/flush in; head, full, empty, count out.
// Read-first on push+pop, so a full FIFO accepts a push alongside a pop.
module uart_rx_fifo #(
  parameter  int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + 1'b1;
      if (do_pop)
        rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: baud divider, OFF/ARM/RUN gating, RX FIFO, bus regs.
// Ports: r_clk, reset (async low), rx_byte/rx_valid in, rx_enable,
// baud_tick, irq out, bus (slave modport). UART_RX_IRQ_EN enables irq.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic         r_clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic         rx_enable,
  output logic         baud_tick,
  uart_rx_ctrl_if.slave bus,
  output logic         irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_ctrl_state_e state_q, state_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             flush_q, flush_d;
  logic             ovr_q, ovr_d;
  logic             ready_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_en_rd;

  logic          rd, wr;
  logic          wr_stat, wr_ctrl, wr_div;
  logic          push, pop;
  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          unused_w;

  assign rd      = bus.sel && !bus.we;
  assign wr      = bus.sel && bus.we;
  assign wr_stat = wr && (bus.addr == REG_STATUS);
  assign wr_ctrl = wr && (bus.addr == REG_CTRL);
  assign wr_div  = wr && (bus.addr == REG_DIV);
  assign unused_w = ^bus.wdata;

  assign en_d    = wr_ctrl ? bus.wdata[CTRL_EN] : en_q;
  assign div_d   = wr_div ? bus.wdata[DIV_W-1:0] : div_q;
  assign flush_d = wr_ctrl && bus.wdata[CTRL_FLUSH];

  // A pending flush wins over a byte arriving in the same cycle.
  assign pop  = rd && (bus.addr == REG_DATA) && !empty;
  assign push = rx_valid && (state_q == RUN) && !flush_q;

  always_comb begin
    ovr_d = ovr_q;
    if (wr_stat && bus.wdata[STAT_OVR])
      ovr_d = 1'b0;
    if (push && full && !pop)
      ovr_d = 1'b1;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (r_clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_q),
    .din_i   (rx_byte),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Transitions follow the register values being written this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF: if (en_d) state_d = ARM;
      ARM: begin
        if (!en_d)
          state_d = OFF;
        else if (div_d != '0)
          state_d = RUN;
      end
      RUN: begin
        if (!en_d || div_d == '0)
          state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  assign rx_enable = (state_q == RUN);
  assign baud_tick = (state_q == RUN) && (div_q != '0)
                   && (cnt_q == div_q - 1'b1);

  always_comb begin
    cnt_d = '0;
    if (state_q == RUN && !wr_div && !baud_tick)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (1'b1)
        (bus.addr == REG_DATA):
          rdata_d = {24'b0, empty ? 8'h00 : head};
        (bus.addr == REG_STATUS):
          rdata_d = {23'b0, ovr_q, full, empty,
                     1'b0, 5'(count)};
        (bus.addr == REG_CTRL):
          rdata_d = {29'b0, 1'b0, irq_en_rd, en_q};
        default:
          rdata_d = 32'(div_q);
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      state_q <= OFF;
      div_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      ovr_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      flush_q <= flush_d;
      ovr_q   <= ovr_d;
      ready_q <= bus.sel;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

`ifdef UART_RX_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl)
        irq_en_q <= bus.wdata[CTRL_IRQ];
      irq_q <= irq_en_q && (!empty || ovr_q);
    end
  end
`else
  assign irq_en_rd = 1'b0;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model
// compared every cycle, plus directed reads with literal expectations.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

`ifdef UART_RX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_enable;
  logic       baud_tick;
  logic       irq;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .DIV_W(16)
  ) dut (
    .r_clk     (clk),
    .reset     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_enable (rx_enable),
    .baud_tick (baud_tick),
    .bus       (bus),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 off, 1 armed, 2 running.
  logic [7:0]  q[$];
  int          m_mode = 0;
  bit          m_en = 0;
  bit          m_irqen = 0;
  bit          m_ovr = 0;
  bit          m_flush = 0;
  int          m_div = 0;
  int          m_phase = 0;
  bit          e_ready = 0;
  logic [31:0] e_rdata = '0;
  bit          e_irq = 0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(q.size());
    if (m_ovr) s = s + 32'h100;
    if (q.size() == DEPTH) s = s + 32'h80;
    if (q.size() == 0) s = s + 32'h40;
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_mode = 0; m_en = 0; m_irqen = 0;
        m_ovr = 0; m_flush = 0; m_div = 0;
        m_phase = 0; e_ready = 0; e_rdata = '0;
        e_irq = 0;
      end else begin
        bit rd, wrt, pop, push, drop, dwr, nflush;
        int prev;
        logic [31:0] rv;
        logic [31:0] wd;
        wd  = bus.wdata;
        rd  = bus.sel && !bus.we;
        wrt = bus.sel && bus.we;
        e_irq = IRQ && m_irqen && (q.size() != 0 || m_ovr);
        rv = '0;
        if (rd) begin
          case (bus.addr)
            2'd0: rv = (q.size() != 0) ? 32'(q[0]) : '0;
            2'd1: rv = m_status();
            2'd2: rv = 32'(m_en) + (m_irqen ? 32'd2 : 32'd0);
            default: rv = 32'(m_div);
          endcase
        end
        pop  = rd && bus.addr == 2'd0 && q.size() != 0;
        push = rx_valid && m_mode == 2 && !m_flush;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) q.push_back(rx_byte);
          else drop = 1;
        end
        if (m_flush) q.delete();
        if (drop) m_ovr = 1;
        else if (wrt && bus.addr == 2'd1 && wd[8]) m_ovr = 0;
        nflush = 0;
        if (wrt && bus.addr == 2'd2) begin
          m_en    = wd[0];
          m_irqen = IRQ && wd[1];
          nflush  = wd[2];
        end
        dwr = wrt && bus.addr == 2'd3;
        if (dwr) m_div = int'(wd[15:0]);
        prev = m_mode;
        if (!m_en) m_mode = 0;
        else if (prev == 0) m_mode = 1;
        else if (m_div != 0) m_mode = 2;
        else if (prev == 2) m_mode = 0;
        if (m_mode == 2 && prev == 2 && !dwr) m_phase++;
        else m_phase = 0;
        m_flush = nflush;
        e_ready = bus.sel;
        e_rdata = rv;
      end
    end
  end

  always @(negedge clk) begin
    bit etick;
    etick = m_mode == 2 && m_div != 0
          && (m_phase % m_div) == m_div - 1;
    check("rx_enable", 32'(rx_enable), 32'(m_mode == 2));
    check("baud_tick", 32'(baud_tick), 32'(etick));
    check("ready", 32'(bus.ready), 32'(e_ready));
    check("rdata", bus.rdata, e_rdata);
    check("irq", 32'(irq), 32'(e_irq));
  end

  task automatic cyc(bit s, bit w, logic [1:0] a,
                     logic [31:0] d, bit v, logic [7:0] b);
    bus.sel  = s;
    bus.we   = w;
    bus.addr = a;
    bus.wdata = d;
    rx_valid = v;
    rx_byte  = b;
    @(posedge clk);
    #1;
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, 32'h0, 0, 8'h00);
  endtask

  task automatic wreg(logic [1:0] a, logic [31:0] d);
    cyc(1, 1, a, d, 0, 8'h00);
  endtask

  task automatic rreg(string name, logic [1:0] a,
                      logic [31:0] exp);
    cyc(1, 0, a, 32'h0, 0, 8'h00);
    check(name, bus.rdata, exp);
  endtask

  task automatic pushb(logic [7:0] b);
    cyc(0, 0, 2'd0, 32'h0, 1, b);
  endtask

  initial begin
    int ticks;
    logic [7:0] exp_b[8];
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_enable", 32'(rx_enable), 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    idle();

    wreg(2'd3, 32'd4);
    wreg(2'd2, 32'h1);
    check("arm_rx_enable", 32'(rx_enable), 32'h0);
    idle();
    check("run_rx_enable", 32'(rx_enable), 32'h1);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      if (baud_tick) ticks++;
      idle();
    end
    check("tick_count", 32'(ticks), 32'd2);

    pushb(8'h41);
    pushb(8'h42);
    rreg("data_41", 2'd0, 32'h41);
    rreg("data_42", 2'd0, 32'h42);
    rreg("stat_empty", 2'd1, 32'h40);
    rreg("data_empty", 2'd0, 32'h0);

    for (int i = 0; i < 9; i++) pushb(8'h10 + 8'(i));
    rreg("stat_ovr", 2'd1, 32'h188);
    wreg(2'd1, 32'h100);
    rreg("stat_clr", 2'd1, 32'h088);

    cyc(1, 0, 2'd0, 32'h0, 1, 8'h55);
    check("full_pushpop", bus.rdata, 32'h10);
    rreg("stat_full", 2'd1, 32'h088);

    wreg(2'd2, 32'h0);
    check("off_rx_enable", 32'(rx_enable), 32'h0);
    pushb(8'h77);
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h11 + 8'(i);
    exp_b[7] = 8'h55;
    for (int i = 0; i < 8; i++)
      rreg("drain", 2'd0, 32'(exp_b[i]));
    rreg("stat_drained", 2'd1, 32'h40);

    wreg(2'd2, 32'h1);
    idle();
    pushb(8'h01);
    pushb(8'h02);
    wreg(2'd2, 32'h5);
    pushb(8'h03);
    rreg("stat_flush", 2'd1, 32'h40);
    pushb(8'h04);
    rreg("data_after_flush", 2'd0, 32'h04);

    wreg(2'd3, 32'd0);
    check("div0_rx_enable", 32'(rx_enable), 32'h0);
    repeat (6) idle();

    wreg(2'd3, 32'd3);
    wreg(2'd2, 32'h3);
    rreg("ctrl_rd", 2'd2, IRQ ? 32'h3 : 32'h1);
    pushb(8'hA5);
    check("irq_lat", 32'(irq), 32'h0);
    idle();
    check("irq_set", 32'(irq), 32'(IRQ));
    rreg("data_a5", 2'd0, 32'hA5);
    idle();
    check("irq_clr", 32'(irq), 32'h0);

    rreg("div_rd", 2'd3, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus.ready), 32'h0);
    check("rst_mid_rdata", bus.rdata, 32'h0);
    check("rst_mid_rxen", 32'(rx_enable), 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    #10;
    rst_n = 1'b1;
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
